// File: rtl/layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : layer_scheduler
// Purpose  : Holds the per-layer configuration (maps + ypos) for a bank of
//            N_LAYERS draw_layer instances. On each frame tick the layers
//            scroll down by scroll_step. A layer passing BOTTOM_Y wraps to
//            the top and gets a new map from the level generator over a
//            req/ack handshake. All updates are built in a working set and
//            copied to the outputs in a single COMMIT cycle.
// Ports    : pclk, rst (async, active-low)
//            vsync_in, scroll_en, scroll_step[3:0]  - frame tick / scroll
//            gen_req / gen_ack, gen_*_map[6:0]       - generator handshake
//            layer_map_o, block_type_o, bonus_map_o  - 7 bits per slot
//            ypos_o (12 bits per slot), module_en_o  - committed layer set
//            busy, frame_overrun, layers_spawned     - status
// Option   : define BONUS_CLEAR_EN to add bonus_clr, bonus_clr_slot and
//            bonus_clr_col (clears one bonus bit of one slot).
// Revision : 1.0 - initial release
// ============================================================================
module layer_scheduler #(
    parameter int N_LAYERS = 4,
    parameter int TOP_Y    = 100,
    parameter int SPACING  = 150,
    parameter int BOTTOM_Y = 700,
    localparam int SLOT_W  = $clog2(N_LAYERS)
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  vsync_in,
    input  logic                  scroll_en,
    input  logic [3:0]            scroll_step,
    output logic                  gen_req,
    input  logic                  gen_ack,
    input  logic [6:0]            gen_layer_map,
    input  logic [6:0]            gen_block_type,
    input  logic [6:0]            gen_bonus_map,
`ifdef BONUS_CLEAR_EN
    input  logic                  bonus_clr,
    input  logic [SLOT_W-1:0]     bonus_clr_slot,
    input  logic [2:0]            bonus_clr_col,
`endif
    output logic [7*N_LAYERS-1:0]  layer_map_o,
    output logic [7*N_LAYERS-1:0]  block_type_o,
    output logic [7*N_LAYERS-1:0]  bonus_map_o,
    output logic [12*N_LAYERS-1:0] ypos_o,
    output logic [N_LAYERS-1:0]    module_en_o,
    output logic                   busy,
    output logic                   frame_overrun,
    output logic [15:0]            layers_spawned
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_SCROLL = 3'd2,
        S_CHECK  = 3'd3,
        S_REQ    = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_LAYERS - 1);
    localparam logic [11:0]       BOTTOM    = 12'(BOTTOM_Y);
    localparam logic [11:0]       WRAP      = 12'(N_LAYERS * SPACING);

    state_t                    state;
    logic [SLOT_W-1:0]         slot;
    logic                      init_phase;   // REQ returns to INIT instead of CHECK
    logic                      vsync_q;
    logic                      tick;

    logic [N_LAYERS-1:0][11:0] work_ypos;
    logic [N_LAYERS-1:0][6:0]  work_map;
    logic [N_LAYERS-1:0][6:0]  work_type;
    logic [N_LAYERS-1:0][6:0]  work_bonus;
    logic [N_LAYERS-1:0]       work_valid;

    logic [N_LAYERS-1:0][11:0] out_ypos;
    logic [N_LAYERS-1:0][6:0]  out_map;
    logic [N_LAYERS-1:0][6:0]  out_type;
    logic [N_LAYERS-1:0][6:0]  out_bonus;

    assign tick         = vsync_in & ~vsync_q;
    assign ypos_o       = out_ypos;
    assign layer_map_o  = out_map;
    assign block_type_o = out_type;
    assign bonus_map_o  = out_bonus;

`ifdef BONUS_CLEAR_EN
    logic clr_hit;
    assign clr_hit = bonus_clr && (bonus_clr_col <= 3'd6) &&
                     ({{(32-SLOT_W){1'b0}}, bonus_clr_slot} < 32'(N_LAYERS));
`endif

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state          <= S_INIT;
            slot           <= '0;
            init_phase     <= 1'b1;
            vsync_q        <= 1'b0;
            gen_req        <= 1'b0;
            busy           <= 1'b0;
            frame_overrun  <= 1'b0;
            layers_spawned <= 16'd0;
            module_en_o    <= '0;
            work_map       <= '0;
            work_type      <= '0;
            work_bonus     <= '0;
            work_valid     <= '0;
            out_ypos       <= '0;
            out_map        <= '0;
            out_type       <= '0;
            out_bonus      <= '0;
            for (int i = 0; i < N_LAYERS; i++) begin
                work_ypos[i] <= 12'(TOP_Y + i * SPACING);
            end
        end else begin
            vsync_q       <= vsync_in;
            // Ticks outside IDLE are dropped, never queued.
            frame_overrun <= tick && (state != S_IDLE);

            case (state)
                S_INIT: begin
                    gen_req <= 1'b1;
                    busy    <= 1'b1;
                    state   <= S_REQ;
                end
                S_IDLE: begin
                    if (tick && scroll_en) begin
                        busy  <= 1'b1;
                        state <= S_SCROLL;
                    end
                end
                S_SCROLL: begin
                    for (int i = 0; i < N_LAYERS; i++) begin
                        work_ypos[i] <= work_ypos[i] + {8'd0, scroll_step};
                    end
                    slot  <= '0;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (work_ypos[slot] >= BOTTOM) begin
                        work_ypos[slot] <= work_ypos[slot] - WRAP;
                        gen_req         <= 1'b1;
                        state           <= S_REQ;
                    end else if (slot == LAST_SLOT) begin
                        state <= S_COMMIT;
                    end else begin
                        slot <= slot + SLOT_W'(1);
                    end
                end
                S_REQ: begin
                    if (gen_req && gen_ack) begin
                        work_map[slot]   <= gen_layer_map;
                        work_type[slot]  <= gen_block_type;
                        work_bonus[slot] <= gen_bonus_map;
                        work_valid[slot] <= 1'b1;
                        layers_spawned   <= layers_spawned + 16'd1;
                        gen_req          <= 1'b0;
                        if (slot == LAST_SLOT) begin
                            state <= S_COMMIT;
                        end else begin
                            slot  <= slot + SLOT_W'(1);
                            state <= init_phase ? S_INIT : S_CHECK;
                        end
                    end
                end
                S_COMMIT: begin
                    out_ypos    <= work_ypos;
                    out_map     <= work_map;
                    out_type    <= work_type;
                    out_bonus   <= work_bonus;
                    module_en_o <= work_valid;
                    init_phase  <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase

`ifdef BONUS_CLEAR_EN
            // Placed after the case so a clear overrides a same-cycle fetch
            // or commit of that bit. The output copy is only touched where
            // it would otherwise miss the clear (IDLE, or the COMMIT cycle).
            if (clr_hit) begin
                work_bonus[bonus_clr_slot][bonus_clr_col] <= 1'b0;
                if (state == S_IDLE || state == S_COMMIT) begin
                    out_bonus[bonus_clr_slot][bonus_clr_col] <= 1'b0;
                end
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_scheduler
// Purpose  : Randomized scoreboard bench for layer_scheduler. A reference
//            model predicts each committed layer set; a monitor compares at
//            every commit (busy falling) and checks outputs hold while busy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_scheduler;

    localparam int N        = 4;
    localparam int TOP_Y    = 100;
    localparam int SPACING  = 150;
    localparam int BOTTOM_Y = 700;

    logic            pclk = 1'b0;
    logic            rst = 1'b0;
    logic            vsync_in = 1'b0;
    logic            scroll_en = 1'b0;
    logic [3:0]      scroll_step = 4'd0;
    logic            gen_req;
    logic            gen_ack = 1'b0;
    logic [6:0]      gen_layer_map = 7'd0;
    logic [6:0]      gen_block_type = 7'd0;
    logic [6:0]      gen_bonus_map = 7'd0;
    logic [7*N-1:0]  layer_map_o;
    logic [7*N-1:0]  block_type_o;
    logic [7*N-1:0]  bonus_map_o;
    logic [12*N-1:0] ypos_o;
    logic [N-1:0]    module_en_o;
    logic            busy;
    logic            frame_overrun;
    logic [15:0]     layers_spawned;
`ifdef BONUS_CLEAR_EN
    logic            bonus_clr = 1'b0;
    logic [1:0]      bonus_clr_slot = 2'd0;
    logic [2:0]      bonus_clr_col = 3'd0;
`endif

    layer_scheduler #(
        .N_LAYERS(N), .TOP_Y(TOP_Y), .SPACING(SPACING), .BOTTOM_Y(BOTTOM_Y)
    ) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .scroll_en(scroll_en),
        .scroll_step(scroll_step), .gen_req(gen_req), .gen_ack(gen_ack),
        .gen_layer_map(gen_layer_map), .gen_block_type(gen_block_type),
        .gen_bonus_map(gen_bonus_map),
`ifdef BONUS_CLEAR_EN
        .bonus_clr(bonus_clr), .bonus_clr_slot(bonus_clr_slot),
        .bonus_clr_col(bonus_clr_col),
`endif
        .layer_map_o(layer_map_o), .block_type_o(block_type_o),
        .bonus_map_o(bonus_map_o), .ypos_o(ypos_o), .module_en_o(module_en_o),
        .busy(busy), .frame_overrun(frame_overrun),
        .layers_spawned(layers_spawned)
    );

    always #5 pclk = ~pclk;

    // ---------------- scoreboard bookkeeping ----------------
    typedef struct {
        logic [12*N-1:0] ypos;
        logic [7*N-1:0]  map;
        logic [7*N-1:0]  typ;
        logic [7*N-1:0]  bonus;
        logic [N-1:0]    en;
        logic [15:0]     spawned;
    } frame_t;

    typedef struct {
        logic [6:0] map;
        logic [6:0] typ;
        logic [6:0] bonus;
    } gen_t;

    frame_t exp_q[$];
    gen_t   gen_q[$];

    int checks = 0;
    int failures = 0;
    int ack_delay = 2;
    int exp_ovr = 0;
    int ovr_seen = 0;

    // Reference model: layer set as the next commit should present it.
    int         m_ypos[N];
    logic [6:0] m_map[N];
    logic [6:0] m_type[N];
    logic [6:0] m_bonus[N];
    logic [N-1:0] m_en;
    int         m_spawned;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic gen_t random_layer();
        gen_t g;
        g.map   = 7'($urandom);
        g.typ   = 7'($urandom);
        g.bonus = 7'($urandom);
        return g;
    endfunction

    task automatic model_fetch(input int k, input gen_t g);
        m_map[k]   = g.map;
        m_type[k]  = g.typ;
        m_bonus[k] = g.bonus;
        m_en[k]    = 1'b1;
        m_spawned  = (m_spawned + 1) % 65536;
        gen_q.push_back(g);
    endtask

    task automatic push_expected();
        frame_t f;
        for (int k = 0; k < N; k++) begin
            f.ypos[12*k +: 12] = 12'(m_ypos[k]);
            f.map[7*k +: 7]    = m_map[k];
            f.typ[7*k +: 7]    = m_type[k];
            f.bonus[7*k +: 7]  = m_bonus[k];
        end
        f.en      = m_en;
        f.spawned = 16'(m_spawned);
        exp_q.push_back(f);
    endtask

    task automatic model_reset();
        exp_q.delete();
        gen_q.delete();
        for (int k = 0; k < N; k++) begin
            m_ypos[k]  = TOP_Y + k * SPACING;
            m_map[k]   = 7'd0;
            m_type[k]  = 7'd0;
            m_bonus[k] = 7'd0;
        end
        m_en      = '0;
        m_spawned = 0;
    endtask

    task automatic model_init(input bit fixed_pattern);
        gen_t g;
        for (int k = 0; k < N; k++) begin
            if (fixed_pattern) begin
                g.map = 7'b1010101; g.typ = 7'b1010101; g.bonus = 7'b1010101;
            end else begin
                g = random_layer();
            end
            model_fetch(k, g);
        end
        push_expected();
    endtask

    // One scrolled frame: move everything, wrap crossers in slot order.
    task automatic model_frame(input int step);
        for (int k = 0; k < N; k++) m_ypos[k] += step;
        for (int k = 0; k < N; k++) begin
            if (m_ypos[k] >= BOTTOM_Y) begin
                m_ypos[k] -= N * SPACING;
                model_fetch(k, random_layer());
            end
        end
        push_expected();
    endtask

    function automatic bit will_fetch(input int step);
        bit any = 1'b0;
        for (int k = 0; k < N; k++) if (m_ypos[k] + step >= BOTTOM_Y) any = 1'b1;
        return any;
    endfunction

    // ---------------- level generator ----------------
    initial begin
        int wait_cnt = 0;
        gen_t g;
        forever begin
            @(negedge pclk);
            if (!rst) begin
                gen_ack  = 1'b0;
                wait_cnt = 0;
            end else if (gen_ack) begin
                gen_ack = 1'b0;
            end else if (gen_req) begin
                if (wait_cnt >= ack_delay) begin
                    if (gen_q.size() == 0) begin
                        check("gen_unexpected_req", 64'd1, 64'd0);
                        g.map = 7'd0; g.typ = 7'd0; g.bonus = 7'd0;
                    end else begin
                        g = gen_q.pop_front();
                    end
                    gen_layer_map  = g.map;
                    gen_block_type = g.typ;
                    gen_bonus_map  = g.bonus;
                    gen_ack        = 1'b1;
                    wait_cnt       = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit     prev_busy = 1'b0;
        frame_t snap;
        frame_t f;
        snap.ypos = '0; snap.map = '0; snap.typ = '0; snap.bonus = '0;
        snap.en = '0; snap.spawned = '0;
        forever begin
            @(negedge pclk);
            if (!rst) begin
                prev_busy = 1'b0;
                snap.ypos = '0; snap.map = '0; snap.typ = '0; snap.bonus = '0;
                snap.en = '0;
            end else begin
                if (frame_overrun) ovr_seen++;
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        check("commit_unexpected", 64'd1, 64'd0);
                    end else begin
                        f = exp_q.pop_front();
                        check("commit_ypos", 64'(ypos_o), 64'(f.ypos));
                        check("commit_layer_map", 64'(layer_map_o), 64'(f.map));
                        check("commit_block_type", 64'(block_type_o), 64'(f.typ));
                        check("commit_bonus_map", 64'(bonus_map_o), 64'(f.bonus));
                        check("commit_module_en", 64'(module_en_o), 64'(f.en));
                        check("commit_spawned", 64'(layers_spawned), 64'(f.spawned));
                        snap = f;
                    end
                end else if (busy) begin
                    check("hold_ypos_en", {12'd0, ypos_o, module_en_o}, {12'd0, snap.ypos, snap.en});
                    check("hold_maps", {layer_map_o, block_type_o}, {snap.map, snap.typ});
                end
                prev_busy = busy;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < limit) begin
            @(negedge pclk);
            n++;
        end
        if (n >= limit) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic frame(input int step, input bit en, input bit probe);
        int n;
        wait_idle(3000);
        @(negedge pclk);
        scroll_en   = en;
        scroll_step = 4'(step);
        if (en) model_frame(step);
        vsync_in = 1'b1;
        repeat (3) @(negedge pclk);
        vsync_in = 1'b0;
        if (!en) check("noscroll_idle", 64'(busy), 64'd0);
        if (probe) begin
            n = 0;
            while (!gen_req && n < 50) begin @(negedge pclk); n++; end
            check("probe_req_seen", 64'(gen_req), 64'd1);
            repeat (5) @(negedge pclk);
            vsync_in = 1'b1;
            exp_ovr++;
            @(negedge pclk);
            vsync_in = 1'b0;
            repeat (10) @(negedge pclk);
            check("req_held_after_overrun", 64'(gen_req), 64'd1);
        end
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        int guard;
        repeat (3) @(negedge pclk);
        model_reset();
        model_init(1'b1);
        check("rst_gen_req", 64'(gen_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_module_en", 64'(module_en_o), 64'd0);
        check("rst_spawned", 64'(layers_spawned), 64'd0);
        check("rst_ypos_o", 64'(ypos_o), 64'd0);
        #2 rst = 1'b1;
        wait_idle(3000);

        // Steady scroll: slot 3 reaches 700 on the 15th frame and wraps.
        for (int i = 0; i < 15; i++) frame(10, 1'b1, 1'b0);

        // Randomized frames, including disabled-scroll ticks and step 0.
        for (int i = 0; i < 40; i++) begin
            frame($urandom_range(0, 15), ($urandom_range(0, 4) != 0), 1'b0);
        end

        // Overrun during a long-held request.
        guard = 0;
        while (!will_fetch(15) && guard < 80) begin
            frame(15, 1'b1, 1'b0);
            guard++;
        end
        ack_delay = 2000;
        frame(15, 1'b1, 1'b1);
        wait_idle(6000);
        ack_delay = 2;
        check("overrun_pulses", 64'(ovr_seen), 64'(exp_ovr));

        // Reset asserted while a request is outstanding.
        @(negedge pclk);
        rst = 1'b0;
        model_reset();
        model_init(1'b0);
        @(negedge pclk);
        #2 rst = 1'b1;
        guard = 0;
        while (!gen_req && guard < 50) begin @(negedge pclk); guard++; end
        check("midreq_req_seen", 64'(gen_req), 64'd1);
        @(negedge pclk);
        #2 rst = 1'b0;
        #1;
        check("midreq_gen_req", 64'(gen_req), 64'd0);
        check("midreq_ypos_o", 64'(ypos_o), 64'd0);
        check("midreq_module_en", 64'(module_en_o), 64'd0);
        check("midreq_spawned", 64'(layers_spawned), 64'd0);
        model_reset();
        model_init(1'b0);
        @(negedge pclk);
        #2 rst = 1'b1;
        wait_idle(3000);

        for (int i = 0; i < 20; i++) begin
            frame($urandom_range(0, 15), ($urandom_range(0, 4) != 0), 1'b0);
        end
        wait_idle(3000);
        repeat (5) @(negedge pclk);
        check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("final_gen_queue_empty", 64'(gen_q.size()), 64'd0);
        check("final_spawned", 64'(layers_spawned), 64'(m_spawned));
        check("final_overrun_pulses", 64'(ovr_seen), 64'(exp_ovr));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
